brnch_rdrct_ctrl: RTL

This block consumes the decode-stage branch decision (take_branch) and the resolved target, and turns them into fetch-side actions. It drives the PC redirect mux and squashes the wrong-path instruction in IF/ID. When instruction memory is stalled it holds a pending redirect. It also keeps saturating counts of resolved and taken branches for performance debug. It sits between the ID-stage branch checker and the fetch stage's PC register.

---
 rtl/brnch_rdrct_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/brnch_rdrct_ctrl.sv
// rtl/brnch_rdrct_ctrl.sv - turns ID-stage branch decisions into PC redirect and IF/ID squash
// Holds a taken redirect across imem_stall and keeps saturating branch counters.
module brnch_rdrct_ctrl #(
   parameter int PC_W  = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             take_branch,
   input  logic             id_brnch_valid,
   input  logic             id_stall,
   input  logic [PC_W-1:0]  brnch_target,
   input  logic             imem_stall,
   output logic             pc_sel,
   output logic [PC_W-1:0]  pc_redirect,
   output logic             flush_ifid,
   output logic             rdrct_pend,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] tkn_cnt
);

   typedef enum logic {IDLE, PEND} state_t;

   state_t            state;
   logic [PC_W-1:0]   tgt_q;
   logic [CNT_W-1:0]  br_cnt_q;
   logic [CNT_W-1:0]  tkn_cnt_q;
   logic              res;
   logic              res_tkn;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // A branch held in ID by a hazard resolves only when the stall drops.
   assign res     = id_brnch_valid & ~id_stall & (state == IDLE);
   assign res_tkn = res & take_branch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tgt_q     <= '0;
         br_cnt_q  <= '0;
         tkn_cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (res_tkn && imem_stall) begin
                  tgt_q <= brnch_target;
                  state <= PEND;
               end
            end
            PEND: begin
               if (!imem_stall)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (res && (br_cnt_q != '1))
            br_cnt_q <= br_cnt_q + CNT_ONE;
         if (res_tkn && (tkn_cnt_q != '1))
            tkn_cnt_q <= tkn_cnt_q + CNT_ONE;
      end
   end

   // Redirect outputs are combinational so a taken branch redirects with zero latency.
   always_comb begin
      pc_sel      = 1'b0;
      pc_redirect = '0;
      flush_ifid  = 1'b0;
      rdrct_pend  = 1'b0;
      br_cnt      = '0;
      tkn_cnt     = '0;
      if (!rst) begin
         br_cnt  = br_cnt_q;
         tkn_cnt = tkn_cnt_q;
         if (state == PEND) begin
            pc_redirect = tgt_q;
            pc_sel      = ~imem_stall;
            flush_ifid  = 1'b1;
            rdrct_pend  = 1'b1;
         end else begin
            pc_redirect = brnch_target;
            pc_sel      = res_tkn & ~imem_stall;
            flush_ifid  = res_tkn;
         end
      end
   end

endmodule
